// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read port and packed-word stream bundle for fifo_rd_packer
interface fifo_rd_packer_if #(
  parameter int WORD_BYTES = 4
);
  logic                    fifo_empty;
  logic                    fifo_rd_en;
  logic [7:0]              fifo_d_out;
  logic [8*WORD_BYTES-1:0] m_data;
  logic [WORD_BYTES-1:0]   m_keep;
  logic                    m_valid;
  logic                    m_ready;
  logic                    busy;

  modport master (
    input  fifo_empty, fifo_d_out, m_ready,
    output fifo_rd_en, m_data, m_keep, m_valid, busy
  );

  modport slave (
    output fifo_empty, fifo_d_out, m_ready,
    input  fifo_rd_en, m_data, m_keep, m_valid, busy
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs FIFO bytes little-endian into words; FLUSH_TIMEOUT_EN adds idle flush of partial words
module fifo_rd_packer #(
  parameter int WORD_BYTES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  fifo_rd_packer_if.master bus
);
  localparam int            LW    = $clog2(WORD_BYTES + 1);
  localparam int            DW    = 8 * WORD_BYTES;
  localparam logic [LW-1:0] LANES = LW'(WORD_BYTES);

  typedef enum logic {FILL, FULL} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         lane_cnt, lane_d, lane_cap;
  logic                  inflight;
  logic [DW-1:0]         acc_q, acc_d, acc_merged;
  logic [DW-1:0]         out_data;
  logic [WORD_BYTES-1:0] out_keep, xfer_keep, part_keep;
  logic                  out_valid, out_free, do_xfer, pop, flush;

  // Pops are bounded by free lanes so a word never needs more bytes than it has room for.
  assign pop = rd_rst && !bus.fifo_empty &&
               (({1'b0, lane_cnt} + {{LW{1'b0}}, inflight}) < {1'b0, LANES});
  assign lane_cap = lane_cnt + {{(LW-1){1'b0}}, inflight};
  assign out_free = !out_valid || bus.m_ready;

  // Assembly including the byte landing this cycle, so a completing word can leave at once.
  always_comb begin
    acc_merged = acc_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (inflight && lane_cnt == LW'(i)) acc_merged[8*i +: 8] = bus.fifo_d_out;
    end
  end

  // Keep mask covering only the lanes filled so far.
  always_comb begin
    part_keep = '0;
    for (int i = 0; i < WORD_BYTES; i++) part_keep[i] = (LW'(i) < lane_cnt);
  end

`ifdef FLUSH_TIMEOUT_EN
  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;

  assign tmo_run = (lane_cnt != '0) && !inflight && bus.fifo_empty;
  assign flush   = tmo_run && (tmo_cnt == TMO_LAST) && (state_q == FILL) && out_free && !pop;

  // Idle counter: saturates at the flush point, restarts on any pop or word transfer.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      tmo_cnt <= '0;
    end else if (!tmo_run || do_xfer) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;

  // Without the flush feature a partial word simply waits; TIMEOUT has no effect.
  assign flush          = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Assembly FSM: complete words move to the output register when it is free, else park in FULL.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_cap;
    acc_d     = acc_merged;
    do_xfer   = 1'b0;
    xfer_keep = '0;
    case (state_q)
      FILL: begin
        if (lane_cap == LANES) begin
          if (out_free) begin
            do_xfer   = 1'b1;
            xfer_keep = '1;
          end else begin
            state_d = FULL;
          end
        end else if (flush) begin
          do_xfer   = 1'b1;
          xfer_keep = part_keep;
        end
      end
      FULL: begin
        if (out_free) begin
          do_xfer   = 1'b1;
          xfer_keep = '1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (do_xfer) begin
      lane_d = '0;
      acc_d  = '0;
    end
  end

  // Assembly state, lane counter and one-cycle pop pipeline.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state_q  <= FILL;
      lane_cnt <= '0;
      inflight <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      lane_cnt <= lane_d;
      inflight <= pop;
      acc_q    <= acc_d;
    end
  end

  // Output register: loads on transfer, clears after acceptance so idle lanes read zero.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else if (do_xfer) begin
      out_data  <= acc_merged;
      out_keep  <= xfer_keep;
      out_valid <= 1'b1;
    end else if (out_valid && bus.m_ready) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.m_data     = out_data;
  assign bus.m_keep     = out_keep;
  assign bus.m_valid    = out_valid;
  assign bus.busy       = (lane_cnt != '0) || inflight || out_valid;
endmodule
